// File: rtl/mac_pkg.sv
// mac_pkg: shared lane geometry, vector type and accumulator FSM states for the MAC datapath
package mac_pkg;
  localparam int MAC_LANES = 4;
  localparam int MAC_LANE_W = 32;
  typedef logic [MAC_LANES*MAC_LANE_W-1:0] lane_vec_t;
  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_t;
endpackage

// File: rtl/mac_int32_lane_acc_adder_4.sv
// Adder_4: 128-bit adder, either lane-wise 4x32 (mode=1, no inter-lane carry) or full width (mode=0)
module Adder_4
  import mac_pkg::*;
(
  input  logic      mode,
  input  lane_vec_t X,
  input  lane_vec_t Y,
  output lane_vec_t S
);
  lane_vec_t lane_sum;
  for (genvar g = 0; g < MAC_LANES; g++) begin : g_lane
    assign lane_sum[g*MAC_LANE_W +: MAC_LANE_W] = X[g*MAC_LANE_W +: MAC_LANE_W] + Y[g*MAC_LANE_W +: MAC_LANE_W];
  end
  assign S = mode ? lane_sum : X + Y;
endmodule

// File: rtl/mac_int32_lane_acc.sv
// mac_int32_lane_acc: bias-seeded lane-wise INT32 accumulator over k_len beats with valid/ready result
module mac_int32_lane_acc
  import mac_pkg::*;
#(
  parameter int LANES  = MAC_LANES,
  parameter int LANE_W = MAC_LANE_W,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        k_len,
  input  logic [LANES*LANE_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    busy
);
  acc_state_t state;
  logic [LANES*LANE_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  lane_vec_t sum;
  Adder_4 u_add (
    .mode(1'b1),
    .X   (acc),
    .Y   (in_data),
    .S   (sum)
  );
  // handshake flags come straight from the state register, never from inputs
  assign in_ready  = state == ACC;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= bias;
          cnt   <= k_len;
          state <= k_len != '0 ? ACC : DONE;
        end
        ACC: if (in_valid) begin
          acc   <= sum;
          cnt   <= cnt - 1'b1;
          state <= cnt == CNT_W'(1) ? DONE : ACC;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_int32_lane_acc.sv
// tb_mac_int32_lane_acc: directed job sequence with random beats checked against a lane-sum model
module tb_mac_int32_lane_acc;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [7:0] k_len = '0;
  logic [127:0] bias = '0, in_data = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] out_data;
  int total = 0, bad = 0;
  logic [127:0] beats_q[$];
  always #5 clk = ~clk;
  mac_int32_lane_acc dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] lanes4(input int unsigned a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run_job(input int k, input logic [127:0] b, input int gap_pct, input int hold,
                         input bit poke, input logic [127:0] want, input bit use_want);
    int unsigned m[4];
    int sent = 0, n = 0;
    logic [127:0] d, exp;
    for (int i = 0; i < 4; i++) m[i] = b[32*i +: 32];
    @(negedge clk);
    start = 1; k_len = 8'(k); bias = b;
    @(negedge clk);
    start = 0; bias = rnd128(); n = 1;
    while (sent < k && n < 4000) begin
      chk("in_ready_acc", 128'(in_ready), 128'(1));
      if (poke) begin start = 1; bias = {4{32'd7}}; k_len = 8'd1; end
      in_valid = $urandom_range(99) >= gap_pct;
      if (in_valid) begin
        d = beats_q.size() > 0 ? beats_q.pop_front() : rnd128();
        in_data = d;
        for (int i = 0; i < 4; i++) m[i] = m[i] + d[32*i +: 32];
        sent++;
      end else in_data = rnd128();
      @(negedge clk);
      n++; in_valid = 0; start = 0;
    end
    exp = lanes4(m[3], m[2], m[1], m[0]);
    chk("beats_sent", 128'(sent), 128'(k));
    if (gap_pct == 0) chk("latency", 128'(n), 128'(k + 1));
    chk("out_valid", 128'(out_valid), 128'(1));
    chk("in_ready_done", 128'(in_ready), 128'(0));
    chk("busy_done", 128'(busy), 128'(1));
    chk("out_data", out_data, exp);
    if (use_want) chk("out_data_lit", out_data, want);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1; in_data = rnd128();
      @(negedge clk);
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_data", out_data, exp);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_out_valid", 128'(out_valid), 128'(0));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    rst = 0;
    beats_q.push_back(lanes4(4, 3, 2, 1));
    beats_q.push_back(lanes4(40, 30, 20, 10));
    run_job(2, '0, 0, 0, 0, lanes4(44, 33, 22, 11), 1);
    beats_q.push_back(lanes4(0, 0, 1, 1));
    run_job(1, lanes4(200, 100, 32'hFFFFFFFF, 32'h7FFFFFFF), 0, 0, 0,
            lanes4(200, 100, 0, 32'h80000000), 1);
    run_job(0, lanes4(5, 5, 5, 5), 0, 1, 0, lanes4(5, 5, 5, 5), 1);
    run_job(3, rnd128(), 40, 3, 0, '0, 0);
    run_job(3, rnd128(), 0, 0, 1, '0, 0);
    @(negedge clk);
    start = 1; k_len = 8'd3; bias = rnd128();
    @(negedge clk);
    start = 0; in_valid = 1; in_data = rnd128();
    @(negedge clk);
    in_valid = 0;
    chk("mid_busy", 128'(busy), 128'(1));
    rst = 1;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_out_data", out_data, 128'(0));
    @(negedge clk);
    rst = 0;
    beats_q.push_back(lanes4(2, 2, 2, 2));
    run_job(1, '0, 0, 0, 0, lanes4(2, 2, 2, 2), 1);
    for (int i = 0; i < 255; i++) beats_q.push_back(lanes4(1, 1, 1, 1));
    run_job(255, '0, 0, 0, 0, lanes4(255, 255, 255, 255), 1);
    for (int j = 0; j < 4; j++) run_job($urandom_range(1, 6), rnd128(), 30, $urandom_range(0, 2), 0, '0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
